mips_exec_unit: RTL and testbench
=================================

MIPS_EXEC_UNIT -- requirements
Module: mips_exec_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port instr, input, 32 bits: instruction in execute stage.
REQ-004 SHALL have port wb_we, input, 1 bit: register write enable from writeback.
REQ-005 SHALL have port wb_addr, input, 5 bits: writeback destination register.
REQ-006 SHALL have port wb_data, input, 32 bits: writeback data.
REQ-007 SHALL have port rs_data, output, 32 bits: register[instr[25:21]].
REQ-008 SHALL have port rt_data, output, 32 bits: register[instr[20:16]].
REQ-009 SHALL have port alu_lo, output, 32 bits: ALU low result.
REQ-010 SHALL have port alu_hi, output, 32 bits: ALU high result.
REQ-011 SHALL have port zero, output, 1 bit: alu_lo == 0.
REQ-012 SHALL have port result, output, 32 bits: writeback candidate selected by regsel.
REQ-013 SHALL have these decode outputs: regwrite (1), rdrt (1; 0=rd, 1=rt), alu_src (2; 0=rt, 1=sign-ext imm, 2=zero-ext imm), regsel (2), enhilo (1), memwrite (1), gpio_out_en (1), gpio_in_en (1), alu_op (4), shamt (5).

Function
REQ-014 Register file SHALL hold 32x32-bit registers, with two combinational read ports.
- Write on clk rise when wb_we=1 and wb_addr!=0.
- Register 0 SHALL always read 0.
- A read of the address being written in the same cycle SHALL return wb_data (bypass).
REQ-015 ALU b operand SHALL be rt_data, {16{instr[15]},instr[15:0]}, or {16'b0,instr[15:0]} per alu_src; a operand SHALL be rs_data.
REQ-016 alu_op encoding and results:
- 0 AND, 1 OR, 2 XOR, 3 NOR.
- 4 ADD, 5 SUB: modulo 2^32, no overflow trap.
- 6 MULT signed, 7 MULTU: 64-bit product, {alu_hi,alu_lo}.
- 8 SLT signed, 9 SLTU: result 1 or 0.
- 10 SLL b<<shamt, 11 SRL, 12 SRA.
- 13 LUI: b<<16.
- alu_hi SHALL be 0 for all non-multiply ops.
REQ-017 Opcode 0 (R-type) SHALL decode funct as: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x18 MULT, 0x19 MULTU, 0x10 MFHI, 0x12 MFLO.
- ALU and shift ops: regwrite=1, rdrt=0, alu_src=0, regsel=0.
- MULT/MULTU: enhilo=1, regwrite=0.
- MFHI: regsel=1, regwrite=1. MFLO: regsel=2, regwrite=1.
REQ-018 I-type opcodes SHALL decode with regwrite=1, rdrt=1:
- 0x08/0x09 ADD, 0x0A SLT, 0x0B SLTU (alu_src=1).
- 0x0C AND, 0x0D OR, 0x0E XOR, 0x0F LUI (alu_src=2).
REQ-019 Opcode 0x3E (GPIO read) SHALL give gpio_in_en=1, regwrite=1, rdrt=1, regsel=3.
REQ-020 Opcode 0x3F (GPIO write) SHALL give gpio_out_en=1, regwrite=0.
REQ-021 shamt output SHALL equal instr[10:6].
REQ-022 Unknown opcode or funct SHALL produce all enables 0, alu_op=ADD, alu_src=0, regsel=0.
REQ-023 HI/LO registers SHALL load {alu_hi,alu_lo} on clk rise when enhilo=1.
REQ-024 result SHALL be: regsel 0 alu_lo, 1 HI, 2 LO, 3 0 (the GPIO value is substituted downstream).
REQ-025 memwrite SHALL always be 0 (reserved).

Reset
REQ-026 While rst=0, all 32 registers and HI/LO SHALL clear to 0 immediately.
- Outputs SHALL then reflect zeroed state combinationally.
- Writes arriving during reset SHALL be ignored.

Structure
REQ-027 A shared package SHALL hold the alu_op enum, the opcode/funct constants, and the alu_src/regsel encodings.
REQ-028 The ALU SHALL be a combinational sub-module exec_alu.
- Decode, register file and HI/LO SHALL remain in mips_exec_unit.

Verification
REQ-029 Reset, then write r5=0x00000007 via wb, then instr ADD r3,r5,r5 (0x00A51820) -> alu_lo=0x0000000E, regwrite=1, rdrt=0, zero=0.
REQ-030 wb_we=1, wb_addr=0, wb_data=0xFFFFFFFF, then read r0 -> rs_data=0.
REQ-031 r1=0xFFFFFFFF, ADDI r2,r1,-1 (0x2022FFFF) -> alu_lo=0xFFFFFFFE, alu_src=1; ORI same imm -> b=0x0000FFFF, alu_lo=0xFFFFFFFF.
REQ-032 r1=0xFFFFFFFE, r2=3, MULT, then MFHI/MFLO -> result 0xFFFFFFFF, then 0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-033 SRA with rt=0x80000000, shamt=4 -> 0xF8000000; SRL -> 0x08000000; SLT(-1,1)=1; SLTU(-1,1)=0.
REQ-034 Opcode 0x3E -> gpio_in_en=1, regsel=3; opcode 0x3F -> gpio_out_en=1, regwrite=0; opcode 0x3D -> all enables 0; rst asserted mid-run -> all registers read 0.

Source files
------------

// File: rtl/mips_exec_unit_pkg.sv
// Shared encodings for the MIPS execute stage: ALU operations, opcode/funct
// constants and the operand/result select codes.
package mips_exec_unit_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_NOR   = 4'd3,
    ALU_ADD   = 4'd4,
    ALU_SUB   = 4'd5,
    ALU_MULT  = 4'd6,
    ALU_MULTU = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_SLL   = 4'd10,
    ALU_SRL   = 4'd11,
    ALU_SRA   = 4'd12,
    ALU_LUI   = 4'd13
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_GPIO_RD = 6'h3E;
  localparam logic [5:0] OP_GPIO_WR = 6'h3F;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [1:0] SRC_RT   = 2'd0;
  localparam logic [1:0] SRC_SIMM = 2'd1;
  localparam logic [1:0] SRC_ZIMM = 2'd2;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_HI   = 2'd1;
  localparam logic [1:0] SEL_LO   = 2'd2;
  localparam logic [1:0] SEL_GPIO = 2'd3;

endpackage

// File: rtl/mips_exec_unit_alu.sv
// Combinational ALU: logic, add/sub, 64-bit multiplies, compares and shifts.
// o_hi is only non-zero for the two multiply operations.
module exec_alu
  import mips_exec_unit_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  alu_op_e     i_op,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_lo,
  output logic [31:0] o_hi
);

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;

  assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u = {32'b0, i_a} * {32'b0, i_b};

  always_comb begin
    o_lo = 32'b0;
    o_hi = 32'b0;
    case (i_op)
      ALU_AND:   o_lo = i_a & i_b;
      ALU_OR:    o_lo = i_a | i_b;
      ALU_XOR:   o_lo = i_a ^ i_b;
      ALU_NOR:   o_lo = ~(i_a | i_b);
      ALU_ADD:   o_lo = i_a + i_b;
      ALU_SUB:   o_lo = i_a - i_b;
      ALU_MULT:  {o_hi, o_lo} = w_prod_s;
      ALU_MULTU: {o_hi, o_lo} = w_prod_u;
      ALU_SLT:   o_lo = {31'b0, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU:  o_lo = {31'b0, (i_a < i_b)};
      ALU_SLL:   o_lo = i_b << i_shamt;
      ALU_SRL:   o_lo = i_b >> i_shamt;
      ALU_SRA:   o_lo = $unsigned($signed(i_b) >>> i_shamt);
      ALU_LUI:   o_lo = {i_b[15:0], 16'b0};
      default:   o_lo = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/mips_exec_unit.sv
// MIPS execute stage: instruction decode, 32x32 register file with write
// bypass, HI/LO multiply result registers and writeback result select.
module mips_exec_unit
  import mips_exec_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] alu_lo,
  output logic [31:0] alu_hi,
  output logic        zero,
  output logic [31:0] result,
  output logic        regwrite,
  output logic        rdrt,
  output logic [1:0]  alu_src,
  output logic [1:0]  regsel,
  output logic        enhilo,
  output logic        memwrite,
  output logic        gpio_out_en,
  output logic        gpio_in_en,
  output logic [3:0]  alu_op,
  output logic [4:0]  shamt
);

  logic [31:0] r_regs [32];
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic        w_we;
  logic [31:0] w_b;
  alu_op_e     w_op;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_rs     = instr[25:21];
  assign w_rt     = instr[20:16];
  assign shamt    = instr[10:6];
  assign memwrite = 1'b0;
  assign alu_op   = w_op;

  always_comb begin
    regwrite    = 1'b0;
    rdrt        = 1'b0;
    alu_src     = SRC_RT;
    regsel      = SEL_ALU;
    enhilo      = 1'b0;
    gpio_out_en = 1'b0;
    gpio_in_en  = 1'b0;
    w_op        = ALU_ADD;
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD, FN_ADDU: begin regwrite = 1'b1; w_op = ALU_ADD;  end
          FN_SUB, FN_SUBU: begin regwrite = 1'b1; w_op = ALU_SUB;  end
          FN_AND:          begin regwrite = 1'b1; w_op = ALU_AND;  end
          FN_OR:           begin regwrite = 1'b1; w_op = ALU_OR;   end
          FN_XOR:          begin regwrite = 1'b1; w_op = ALU_XOR;  end
          FN_NOR:          begin regwrite = 1'b1; w_op = ALU_NOR;  end
          FN_SLT:          begin regwrite = 1'b1; w_op = ALU_SLT;  end
          FN_SLTU:         begin regwrite = 1'b1; w_op = ALU_SLTU; end
          FN_SLL:          begin regwrite = 1'b1; w_op = ALU_SLL;  end
          FN_SRL:          begin regwrite = 1'b1; w_op = ALU_SRL;  end
          FN_SRA:          begin regwrite = 1'b1; w_op = ALU_SRA;  end
          FN_MULT:         begin enhilo   = 1'b1; w_op = ALU_MULT;  end
          FN_MULTU:        begin enhilo   = 1'b1; w_op = ALU_MULTU; end
          FN_MFHI:         begin regwrite = 1'b1; regsel = SEL_HI; end
          FN_MFLO:         begin regwrite = 1'b1; regsel = SEL_LO; end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin regwrite = 1'b1; rdrt = 1'b1; alu_src = SRC_SIMM; w_op = ALU_ADD;  end
      OP_SLTI:           begin regwrite = 1'b1; rdrt = 1'b1; alu_src = SRC_SIMM; w_op = ALU_SLT;  end
      OP_SLTIU:          begin regwrite = 1'b1; rdrt = 1'b1; alu_src = SRC_SIMM; w_op = ALU_SLTU; end
      OP_ANDI:           begin regwrite = 1'b1; rdrt = 1'b1; alu_src = SRC_ZIMM; w_op = ALU_AND;  end
      OP_ORI:            begin regwrite = 1'b1; rdrt = 1'b1; alu_src = SRC_ZIMM; w_op = ALU_OR;   end
      OP_XORI:           begin regwrite = 1'b1; rdrt = 1'b1; alu_src = SRC_ZIMM; w_op = ALU_XOR;  end
      OP_LUI:            begin regwrite = 1'b1; rdrt = 1'b1; alu_src = SRC_ZIMM; w_op = ALU_LUI;  end
      OP_GPIO_RD:        begin gpio_in_en = 1'b1; regwrite = 1'b1; rdrt = 1'b1; regsel = SEL_GPIO; end
      OP_GPIO_WR:        gpio_out_en = 1'b1;
      default: ;
    endcase
  end

  // Writes (and therefore the bypass) are suppressed while reset is held.
  assign w_we = wb_we && rst && (wb_addr != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'b0;
    end else if (w_we) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  assign rs_data = (w_rs == 5'd0) ? 32'b0 :
                   (w_we && (wb_addr == w_rs)) ? wb_data : r_regs[w_rs];
  assign rt_data = (w_rt == 5'd0) ? 32'b0 :
                   (w_we && (wb_addr == w_rt)) ? wb_data : r_regs[w_rt];

  always_comb begin
    case (alu_src)
      SRC_SIMM: w_b = {{16{instr[15]}}, instr[15:0]};
      SRC_ZIMM: w_b = {16'b0, instr[15:0]};
      default:  w_b = rt_data;
    endcase
  end

  exec_alu u_alu (
    .i_a     (rs_data),
    .i_b     (w_b),
    .i_op    (w_op),
    .i_shamt (shamt),
    .o_lo    (alu_lo),
    .o_hi    (alu_hi)
  );

  assign zero = (alu_lo == 32'b0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= 32'b0;
      r_lo <= 32'b0;
    end else if (enhilo) begin
      r_hi <= alu_hi;
      r_lo <= alu_lo;
    end
  end

  always_comb begin
    case (regsel)
      SEL_HI:   result = r_hi;
      SEL_LO:   result = r_lo;
      SEL_GPIO: result = 32'b0;
      default:  result = alu_lo;
    endcase
  end

endmodule

// File: tb/tb_mips_exec_unit.sv
// Bench for mips_exec_unit: directed scenarios plus randomized instructions
// checked against an instruction-level reference model of registers and HI/LO.
module tb_mips_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = 5'b0;
  logic [31:0] wb_data = 32'b0;
  logic [31:0] rs_data, rt_data, alu_lo, alu_hi, result;
  logic        zero, regwrite, rdrt, enhilo, memwrite, gpio_out_en, gpio_in_en;
  logic [1:0]  alu_src, regsel;
  logic [3:0]  alu_op;
  logic [4:0]  shamt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_hi = 32'b0;
  logic [31:0] m_lo = 32'b0;
  logic [31:0] cur_instr = 32'b0;
  logic [31:0] exp_q [$];

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] res;
    logic        rw;
    logic        rdrt;
    logic        enhilo;
    logic        gin;
    logic        gout;
    logic [1:0]  src;
    logic [1:0]  sel;
    logic [3:0]  op;
  } exp_t;

  logic [5:0] rfn [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                           6'h2B, 6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h10, 6'h12, 6'h3F};
  logic [5:0] iop [11] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                           6'h3E, 6'h3F, 6'h3D};

  mips_exec_unit dut (
    .clk(clk), .rst(rst), .instr(instr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_data(rs_data), .rt_data(rt_data), .alu_lo(alu_lo), .alu_hi(alu_hi),
    .zero(zero), .result(result), .regwrite(regwrite), .rdrt(rdrt),
    .alu_src(alu_src), .regsel(regsel), .enhilo(enhilo), .memwrite(memwrite),
    .gpio_out_en(gpio_out_en), .gpio_in_en(gpio_in_en), .alu_op(alu_op), .shamt(shamt)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model
  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'b0 : m_regs[a];
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t model_eval(input logic [31:0] ins);
    exp_t e;
    logic [31:0] a, b;
    logic [63:0] p;
    int sh;
    e = '0;
    e.op = 4'd4;
    a = m_read(ins[25:21]);
    b = m_read(ins[20:16]);
    sh = int'(ins[10:6]);
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20, 6'h21: begin e.rw = 1; e.op = 4'd4;  end
        6'h22, 6'h23: begin e.rw = 1; e.op = 4'd5;  end
        6'h24:        begin e.rw = 1; e.op = 4'd0;  end
        6'h25:        begin e.rw = 1; e.op = 4'd1;  end
        6'h26:        begin e.rw = 1; e.op = 4'd2;  end
        6'h27:        begin e.rw = 1; e.op = 4'd3;  end
        6'h2A:        begin e.rw = 1; e.op = 4'd8;  end
        6'h2B:        begin e.rw = 1; e.op = 4'd9;  end
        6'h00:        begin e.rw = 1; e.op = 4'd10; end
        6'h02:        begin e.rw = 1; e.op = 4'd11; end
        6'h03:        begin e.rw = 1; e.op = 4'd12; end
        6'h18:        begin e.enhilo = 1; e.op = 4'd6; end
        6'h19:        begin e.enhilo = 1; e.op = 4'd7; end
        6'h10:        begin e.rw = 1; e.sel = 2'd1; end
        6'h12:        begin e.rw = 1; e.sel = 2'd2; end
        default: ;
      endcase
      6'h08, 6'h09: begin e.rw = 1; e.rdrt = 1; e.src = 2'd1; e.op = 4'd4;  end
      6'h0A:        begin e.rw = 1; e.rdrt = 1; e.src = 2'd1; e.op = 4'd8;  end
      6'h0B:        begin e.rw = 1; e.rdrt = 1; e.src = 2'd1; e.op = 4'd9;  end
      6'h0C:        begin e.rw = 1; e.rdrt = 1; e.src = 2'd2; e.op = 4'd0;  end
      6'h0D:        begin e.rw = 1; e.rdrt = 1; e.src = 2'd2; e.op = 4'd1;  end
      6'h0E:        begin e.rw = 1; e.rdrt = 1; e.src = 2'd2; e.op = 4'd2;  end
      6'h0F:        begin e.rw = 1; e.rdrt = 1; e.src = 2'd2; e.op = 4'd13; end
      6'h3E:        begin e.gin = 1; e.rw = 1; e.rdrt = 1; e.sel = 2'd3; end
      6'h3F:        e.gout = 1;
      default: ;
    endcase
    if (e.src == 2'd1) b = 32'(signed'(ins[15:0]));
    if (e.src == 2'd2) b = 32'(ins[15:0]);
    case (e.op)
      4'd0:  e.lo = a & b;
      4'd1:  e.lo = a | b;
      4'd2:  e.lo = a ^ b;
      4'd3:  e.lo = ~(a | b);
      4'd4:  e.lo = 32'(longint'(a) + longint'(b));
      4'd5:  e.lo = 32'(longint'(a) - longint'(b));
      4'd6:  begin p = 64'(longint'(int'(a)) * longint'(int'(b))); e.hi = p[63:32]; e.lo = p[31:0]; end
      4'd7:  begin p = 64'(longint'(a) * longint'(b)); e.hi = p[63:32]; e.lo = p[31:0]; end
      4'd8:  e.lo = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9:  e.lo = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd10: e.lo = 32'(longint'(b) * (longint'(1) << sh));
      4'd11: e.lo = 32'(longint'(b) / (longint'(1) << sh));
      4'd12: e.lo = 32'(int'(b) >>> sh);
      4'd13: e.lo = 32'(longint'(b) * 65536);
      default: ;
    endcase
    case (e.sel)
      2'd1:    e.res = m_hi;
      2'd2:    e.res = m_lo;
      2'd3:    e.res = 32'b0;
      default: e.res = e.lo;
    endcase
    return e;
  endfunction

  // Driver tasks
  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    wb_we = 1'b1; wb_addr = addr; wb_data = data;
    @(posedge clk);
    #1;
    wb_we = 1'b0;
    if (rst && addr != 5'd0) m_regs[addr] = data;
  endtask

  task automatic set_instr(input logic [31:0] ins);
    @(negedge clk);
    instr = ins; cur_instr = ins;
    #1;
  endtask

  task automatic commit();
    exp_t e;
    @(posedge clk);
    e = model_eval(cur_instr);
    if (rst && e.enhilo) begin m_hi = e.hi; m_lo = e.lo; end
    #1;
    instr = 32'b0; cur_instr = 32'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'b0;
    rst = 1'b0;
    instr = rtype(5'd5, 5'd6, 5'd1, 5'd0, 6'h20);
    #7;
    checks++; if (rs_data !== 32'b0) begin errors++; $display("FAIL reset_rs: got %h expected 0", rs_data); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", zero); end
    wb_write(5'd9, 32'h1234_5678);
    set_instr(rtype(5'd0, 5'd9, 5'd1, 5'd0, 6'h20));
    checks++; if (rt_data !== 32'b0) begin errors++; $display("FAIL reset_write_ignored: got %h expected 0", rt_data); end
    set_instr(rtype(5'd0, 5'd0, 5'd1, 5'd0, 6'h10));
    checks++; if (result !== 32'b0) begin errors++; $display("FAIL reset_hi: got %h expected 0", result); end
    @(negedge clk);
    rst = 1'b1;
    instr = 32'b0; cur_instr = 32'b0;
  endtask

  task automatic test_add();
    wb_write(5'd5, 32'h0000_0007);
    set_instr(32'h00A5_1820);
    checks++; if (alu_lo !== 32'h0000_000E) begin errors++; $display("FAIL add_lo: got %h expected 0000000e", alu_lo); end
    checks++; if ({regwrite, rdrt, zero} !== 3'b100) begin errors++; $display("FAIL add_ctl: got %b expected 100", {regwrite, rdrt, zero}); end
    checks++; if (alu_hi !== 32'b0 || memwrite !== 1'b0) begin errors++; $display("FAIL add_hi_mem: got %h/%b expected 0/0", alu_hi, memwrite); end
    commit();
  endtask

  task automatic test_r0();
    wb_write(5'd0, 32'hFFFF_FFFF);
    set_instr(rtype(5'd0, 5'd0, 5'd1, 5'd0, 6'h20));
    checks++; if (rs_data !== 32'b0) begin errors++; $display("FAIL r0_read: got %h expected 0", rs_data); end
    commit();
  endtask

  task automatic test_bypass();
    logic [31:0] d;
    d = $urandom;
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 5'd12; wb_data = d;
    instr = rtype(5'd12, 5'd12, 5'd1, 5'd0, 6'h20); cur_instr = instr;
    #1;
    checks++; if (rs_data !== d) begin errors++; $display("FAIL bypass_rs: got %h expected %h", rs_data, d); end
    checks++; if (alu_lo !== 32'(d + d)) begin errors++; $display("FAIL bypass_add: got %h expected %h", alu_lo, 32'(d + d)); end
    @(posedge clk);
    #1;
    wb_we = 1'b0;
    m_regs[12] = d;
    checks++; if (rt_data !== d) begin errors++; $display("FAIL bypass_stored: got %h expected %h", rt_data, d); end
    instr = 32'b0; cur_instr = 32'b0;
  endtask

  task automatic test_imm();
    wb_write(5'd1, 32'hFFFF_FFFF);
    set_instr(32'h2022_FFFF);
    checks++; if (alu_lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL addi_lo: got %h expected fffffffe", alu_lo); end
    checks++; if (alu_src !== 2'd1 || rdrt !== 1'b1) begin errors++; $display("FAIL addi_ctl: got %0d/%b expected 1/1", alu_src, rdrt); end
    commit();
    set_instr(itype(6'h0D, 5'd1, 5'd2, 16'hFFFF));
    checks++; if (alu_lo !== 32'hFFFF_FFFF || alu_src !== 2'd2) begin errors++; $display("FAIL ori: got %h/%0d expected ffffffff/2", alu_lo, alu_src); end
    commit();
    set_instr(itype(6'h0F, 5'd0, 5'd2, 16'h8001));
    checks++; if (alu_lo !== 32'h8001_0000) begin errors++; $display("FAIL lui: got %h expected 80010000", alu_lo); end
    commit();
  endtask

  task automatic test_mult();
    wb_write(5'd1, 32'hFFFF_FFFE);
    wb_write(5'd2, 32'h0000_0003);
    set_instr(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h18));
    checks++; if ({alu_hi, alu_lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mult_alu: got %h%h expected fffffffffffffffa", alu_hi, alu_lo); end
    checks++; if (enhilo !== 1'b1 || regwrite !== 1'b0) begin errors++; $display("FAIL mult_ctl: got %b/%b expected 1/0", enhilo, regwrite); end
    commit();
    set_instr(rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h10));
    checks++; if (result !== 32'hFFFF_FFFF || regsel !== 2'd1) begin errors++; $display("FAIL mfhi: got %h/%0d expected ffffffff/1", result, regsel); end
    commit();
    set_instr(rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h12));
    checks++; if (result !== 32'hFFFF_FFFA || regsel !== 2'd2) begin errors++; $display("FAIL mflo: got %h/%0d expected fffffffa/2", result, regsel); end
    commit();
    set_instr(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h19));
    commit();
    set_instr(rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h10));
    checks++; if (result !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi: got %h expected 00000002", result); end
    commit();
    set_instr(rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h12));
    checks++; if (result !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo: got %h expected fffffffa", result); end
    commit();
  endtask

  task automatic test_shift_slt();
    wb_write(5'd4, 32'h8000_0000);
    set_instr(rtype(5'd0, 5'd4, 5'd3, 5'd4, 6'h03));
    checks++; if (alu_lo !== 32'hF800_0000 || shamt !== 5'd4) begin errors++; $display("FAIL sra: got %h/%0d expected f8000000/4", alu_lo, shamt); end
    set_instr(rtype(5'd0, 5'd4, 5'd3, 5'd4, 6'h02));
    checks++; if (alu_lo !== 32'h0800_0000) begin errors++; $display("FAIL srl: got %h expected 08000000", alu_lo); end
    wb_write(5'd6, 32'hFFFF_FFFF);
    wb_write(5'd7, 32'h0000_0001);
    set_instr(rtype(5'd6, 5'd7, 5'd3, 5'd0, 6'h2A));
    checks++; if (alu_lo !== 32'd1) begin errors++; $display("FAIL slt: got %h expected 1", alu_lo); end
    set_instr(rtype(5'd6, 5'd7, 5'd3, 5'd0, 6'h2B));
    checks++; if (alu_lo !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL sltu: got %h/%b expected 0/1", alu_lo, zero); end
    commit();
  endtask

  task automatic test_gpio_unknown();
    set_instr(itype(6'h3E, 5'd6, 5'd3, 16'h0));
    checks++; if ({gpio_in_en, regwrite, rdrt, regsel, result} !== {3'b111, 2'd3, 32'b0}) begin errors++; $display("FAIL gpio_rd: got %b%b%b %0d %h expected 111 3 0", gpio_in_en, regwrite, rdrt, regsel, result); end
    set_instr(itype(6'h3F, 5'd6, 5'd3, 16'h0));
    checks++; if (gpio_out_en !== 1'b1 || regwrite !== 1'b0) begin errors++; $display("FAIL gpio_wr: got %b/%b expected 1/0", gpio_out_en, regwrite); end
    set_instr(itype(6'h3D, 5'd6, 5'd7, 16'hFFFF));
    checks++; if ({regwrite, enhilo, memwrite, gpio_out_en, gpio_in_en, alu_op, alu_src, regsel} !== {5'b0, 4'd4, 2'd0, 2'd0}) begin errors++; $display("FAIL unknown_op: got %b %0d %0d %0d", {regwrite, enhilo, memwrite, gpio_out_en, gpio_in_en}, alu_op, alu_src, regsel); end
    set_instr(rtype(5'd6, 5'd7, 5'd3, 5'd0, 6'h3F));
    checks++; if (regwrite !== 1'b0 || enhilo !== 1'b0 || alu_op !== 4'd4) begin errors++; $display("FAIL unknown_funct: got %b/%b/%0d expected 0/0/4", regwrite, enhilo, alu_op); end
    commit();
  endtask

  task automatic test_random();
    exp_t e;
    logic [31:0] r, ins;
    logic [31:0] exp_lo;
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        wb_write(5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
      end else begin
        if (r[31]) ins = {6'h00, r[25:6], rfn[$urandom_range(0, 17)]};
        else       ins = {iop[$urandom_range(0, 10)], r[25:0]};
        set_instr(ins);
        e = model_eval(ins);
        exp_q.push_back(e.lo);
        exp_lo = exp_q.pop_front();
        checks++; if (alu_lo !== exp_lo) begin errors++; $display("FAIL rand_lo %h: got %h expected %h", ins, alu_lo, exp_lo); end
        checks++; if (alu_hi !== e.hi) begin errors++; $display("FAIL rand_hi %h: got %h expected %h", ins, alu_hi, e.hi); end
        checks++; if (result !== e.res) begin errors++; $display("FAIL rand_result %h: got %h expected %h", ins, result, e.res); end
        checks++; if (zero !== (e.lo == 32'b0)) begin errors++; $display("FAIL rand_zero %h: got %b", ins, zero); end
        checks++;
        if ({regwrite, rdrt, enhilo, gpio_in_en, gpio_out_en, alu_src, regsel, alu_op} !==
            {e.rw, e.rdrt, e.enhilo, e.gin, e.gout, e.src, e.sel, e.op}) begin
          errors++;
          $display("FAIL rand_decode %h: got %b expected %b", ins,
                   {regwrite, rdrt, enhilo, gpio_in_en, gpio_out_en, alu_src, regsel, alu_op},
                   {e.rw, e.rdrt, e.enhilo, e.gin, e.gout, e.src, e.sel, e.op});
        end
        commit();
      end
    end
  endtask

  task automatic test_reset_midrun();
    wb_write(5'd10, 32'hDEAD_BEEF);
    wb_write(5'd11, 32'h0000_0005);
    set_instr(rtype(5'd10, 5'd11, 5'd0, 5'd0, 6'h19));
    commit();
    set_instr(rtype(5'd10, 5'd11, 5'd3, 5'd0, 6'h10));
    #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'b0;
    m_hi = 32'b0; m_lo = 32'b0;
    checks++; if (rs_data !== 32'b0 || rt_data !== 32'b0) begin errors++; $display("FAIL midrst_regs: got %h/%h expected 0/0", rs_data, rt_data); end
    checks++; if (result !== 32'b0) begin errors++; $display("FAIL midrst_hi: got %h expected 0", result); end
    wb_write(5'd10, 32'h1111_1111);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k < 32; k += 5) begin
      set_instr(rtype(5'(k), 5'(k + 1), 5'd3, 5'd0, 6'h25));
      checks++; if (rs_data !== 32'b0 || rt_data !== 32'b0) begin errors++; $display("FAIL midrst_r%0d: got %h/%h expected 0/0", k, rs_data, rt_data); end
    end
    set_instr(rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h12));
    checks++; if (result !== 32'b0) begin errors++; $display("FAIL midrst_lo: got %h expected 0", result); end
    commit();
  endtask

  initial begin
    test_reset();
    test_add();
    test_r0();
    test_bypass();
    test_imm();
    test_mult();
    test_shift_slt();
    test_gpio_unknown();
    test_random();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
